// File: rtl/bus_mem_responder.sv
// Purpose : slave end of the cpu multiplexed address/data bus, backed by a 16-bit word RAM.
// Latency : ACCESS is entered WAIT_STATES+1 edges after nME is first sampled low; read data then drives until nME/nOE rise.
// Backpressure: nWait (registered, active low) stretches the access by exactly WAIT_STATES cycles.
// Ports   : Clock/nReset (sync, active-low); Data inout (address on ALE, then write data in or read data out);
//           ALE, nME, RnW, nOE from cpu; nWait wait request out; Selected = latched address hits this block.
module bus_mem_responder #(
    parameter int unsigned ADDR_BITS   = 8,
    parameter logic [15:0] BASE        = 16'h0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        Clock,
    input  logic        nReset,
    inout  wire  [15:0] Data,
    input  logic        ALE,
    input  logic        nME,
    input  logic        RnW,
    input  logic        nOE,
    output logic        nWait,
    output logic        Selected
);

    localparam int unsigned DEPTH    = 1 << ADDR_BITS;
    localparam logic [3:0]  CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_ACCESS,
        S_HOLD
    } state_t;

    state_t                 r_state;
    logic [3:0]             r_cnt;
    logic [ADDR_BITS-1:0]   r_addr;
    logic                   r_selected;
    logic                   r_nwait;
    logic [15:0]            r_rd_data;
    logic [15:0]            r_mem [DEPTH];

    state_t                 w_next_state;
    logic [3:0]             w_cnt_nxt;
    logic                   w_mem_we;
    logic                   w_rd_latch;
    logic                   w_decode;
    logic                   w_drive;

    // Only the bits above the RAM index take part in the match.
    assign w_decode = (Data[15:ADDR_BITS] == BASE[15:ADDR_BITS]);

    // ALE overrides whatever access is in flight; it is checked before the state case.
    always_comb begin
        w_next_state = r_state;
        w_cnt_nxt    = r_cnt;
        w_mem_we     = 1'b0;
        if (ALE) begin
            w_next_state = w_decode ? S_ADDR : S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_next_state = S_IDLE;
                end
                S_ADDR: begin
                    if (!nME) begin
                        if (WAIT_STATES == 0) begin
                            w_next_state = S_ACCESS;
                        end else begin
                            w_next_state = S_WAIT;
                            w_cnt_nxt    = CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    // Abort wins over completing the wait.
                    if (nME) begin
                        w_next_state = S_IDLE;
                    end else if (r_cnt == 4'd0) begin
                        w_next_state = S_ACCESS;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
                S_ACCESS: begin
                    if (nME) begin
                        w_next_state = S_IDLE;
                    end else begin
                        w_next_state = S_HOLD;
                        w_mem_we     = !RnW;
                    end
                end
                S_HOLD: begin
                    if (nME) begin
                        w_next_state = S_IDLE;
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    // ACCESS lasts one cycle, so any transition into it is an entry.
    assign w_rd_latch = (w_next_state == S_ACCESS);

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_addr     <= '0;
            r_selected <= 1'b0;
            r_nwait    <= 1'b1;
            r_rd_data  <= 16'h0000;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_nxt;
            // nWait is low exactly while the machine sits in WAIT.
            r_nwait <= (w_next_state != S_WAIT);
            if (ALE) begin
                r_addr     <= Data[ADDR_BITS-1:0];
                r_selected <= w_decode;
            end
            if (w_rd_latch) begin
                r_rd_data <= r_mem[r_addr];
            end
        end
    end

    // RAM contents survive reset; only the write strobe is qualified by it.
    always_ff @(posedge Clock) begin
        if (nReset && w_mem_we) begin
            r_mem[r_addr] <= Data;
        end
    end

    assign w_drive = ((r_state == S_ACCESS) || (r_state == S_HOLD)) &&
                     r_selected && RnW && !nOE && !nME && !ALE;

    assign Data     = w_drive ? r_rd_data : 16'bz;
    assign nWait    = r_nwait;
    assign Selected = r_selected;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Purpose : self-checking bench for bus_mem_responder; three instances (WAIT_STATES 1/3/0) at distinct bases share the controls.
// Latency : reads are checked when nWait returns high (ACCESS entry) against a scoreboard queue filled at issue time.
// Backpressure: nWait low cycles are counted per access and compared with the instance's wait-state setting.
module tb_bus_mem_responder;

    logic        Clock = 1'b0;
    logic        nReset;
    logic        ALE;
    logic        nME;
    logic        RnW;
    logic        nOE;
    logic        tb_oe;
    logic [15:0] tb_dat;

    wire  [15:0] bus0;
    wire  [15:0] bus1;
    wire  [15:0] bus2;
    logic        nwait0, nwait1, nwait2;
    logic        sel0, sel1, sel2;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_q [$];
    logic [15:0] mdl [3][256];

    always #5 Clock = ~Clock;

    // An undriven bus reads as all ones.
    pullup (bus0);
    pullup (bus1);
    pullup (bus2);

    assign bus0 = tb_oe ? tb_dat : 16'bz;
    assign bus1 = tb_oe ? tb_dat : 16'bz;
    assign bus2 = tb_oe ? tb_dat : 16'bz;

    bus_mem_responder #(.ADDR_BITS(8), .BASE(16'h0000), .WAIT_STATES(1)) dut0 (
        .Clock(Clock), .nReset(nReset), .Data(bus0), .ALE(ALE), .nME(nME),
        .RnW(RnW), .nOE(nOE), .nWait(nwait0), .Selected(sel0));

    bus_mem_responder #(.ADDR_BITS(8), .BASE(16'h1000), .WAIT_STATES(3)) dut1 (
        .Clock(Clock), .nReset(nReset), .Data(bus1), .ALE(ALE), .nME(nME),
        .RnW(RnW), .nOE(nOE), .nWait(nwait1), .Selected(sel1));

    bus_mem_responder #(.ADDR_BITS(8), .BASE(16'h2000), .WAIT_STATES(0)) dut2 (
        .Clock(Clock), .nReset(nReset), .Data(bus2), .ALE(ALE), .nME(nME),
        .RnW(RnW), .nOE(nOE), .nWait(nwait2), .Selected(sel2));

    function automatic logic nwait_of(input int k);
        case (k)
            0:       return nwait0;
            1:       return nwait1;
            default: return nwait2;
        endcase
    endfunction

    function automatic logic sel_of(input int k);
        case (k)
            0:       return sel0;
            1:       return sel1;
            default: return sel2;
        endcase
    endfunction

    function automatic logic [15:0] bus_of(input int k);
        case (k)
            0:       return bus0;
            1:       return bus1;
            default: return bus2;
        endcase
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Runs one access on instance k and leaves the bus in HOLD (nME still low).
    task automatic do_access(input int k, input logic [15:0] addr, input logic rd,
                             input logic [15:0] wdata, input int exp_ws);
        int  lows;
        bit  done;
        logic [15:0] exp_v;
        ALE    = 1'b1;
        nME    = 1'b1;
        nOE    = 1'b1;
        RnW    = rd;
        tb_dat = addr;
        tb_oe  = 1'b1;
        tick();
        total++;
        if (sel_of(k) !== 1'b1) begin
            bad++;
            $display("FAIL select k=%0d addr=%h got=%b want=1", k, addr, sel_of(k));
        end
        ALE = 1'b0;
        nME = 1'b0;
        if (rd) begin
            tb_oe = 1'b0;
            nOE   = 1'b0;
            exp_q.push_back(mdl[k][addr[7:0]]);
        end else begin
            tb_dat = wdata;
        end
        lows = 0;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            tick();
            if (nwait_of(k) === 1'b1) begin
                done = 1'b1;
            end else begin
                lows++;
                if (rd) begin
                    total++;
                    if (bus_of(k) !== 16'hFFFF) begin
                        bad++;
                        $display("FAIL drive_in_wait k=%0d got=%h want=ffff", k, bus_of(k));
                    end
                end
            end
        end
        total++;
        if (!done || lows != exp_ws) begin
            bad++;
            $display("FAIL wait_count k=%0d addr=%h got=%0d want=%0d done=%0d", k, addr, lows, exp_ws, done);
        end
        if (rd) begin
            exp_v = exp_q.pop_front();
            total++;
            if (bus_of(k) !== exp_v) begin
                bad++;
                $display("FAIL rd_access k=%0d addr=%h got=%h want=%h", k, addr, bus_of(k), exp_v);
            end
            tick();
            total++;
            if (bus_of(k) !== exp_v) begin
                bad++;
                $display("FAIL rd_hold k=%0d addr=%h got=%h want=%h", k, addr, bus_of(k), exp_v);
            end
        end else begin
            mdl[k][addr[7:0]] = wdata;
            tick();
        end
    endtask

    task automatic bus_release(input int k);
        nME   = 1'b1;
        nOE   = 1'b1;
        RnW   = 1'b1;
        tb_oe = 1'b0;
        tick();
        total++;
        if (nwait_of(k) !== 1'b1 || bus_of(k) !== 16'hFFFF) begin
            bad++;
            $display("FAIL release k=%0d nwait=%b bus=%h want nwait=1 bus=ffff", k, nwait_of(k), bus_of(k));
        end
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        ALE    = 1'b0;
        nME    = 1'b1;
        nOE    = 1'b1;
        RnW    = 1'b1;
        tb_oe  = 1'b0;
        tb_dat = 16'h0000;
        tick();
        tick();
        nReset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            total++;
            if ({nwait0, nwait1, nwait2} !== 3'b111 || {sel0, sel1, sel2} !== 3'b000 ||
                bus0 !== 16'hFFFF || bus1 !== 16'hFFFF || bus2 !== 16'hFFFF) begin
                bad++;
                $display("FAIL reset cyc=%0d nwait=%b%b%b sel=%b%b%b bus=%h/%h/%h want 111/000/ffff",
                         c, nwait0, nwait1, nwait2, sel0, sel1, sel2, bus0, bus1, bus2);
            end
            tick();
        end
    endtask

    task automatic test_write_ws1();
        do_access(0, 16'h0012, 1'b0, 16'hBEEF, 1);
        bus_release(0);
    endtask

    task automatic test_read_ws1();
        do_access(0, 16'h0012, 1'b1, 16'h0000, 1);
        nOE = 1'b1;
        tick();
        total++;
        if (bus0 !== 16'hFFFF) begin
            bad++;
            $display("FAIL noe_release got=%h want=ffff", bus0);
        end
        bus_release(0);
    endtask

    task automatic test_unselected();
        ALE    = 1'b1;
        nME    = 1'b1;
        RnW    = 1'b0;
        tb_dat = 16'h0112;
        tb_oe  = 1'b1;
        tick();
        ALE    = 1'b0;
        nME    = 1'b0;
        tb_dat = 16'h1234;
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if ({sel0, sel1, sel2} !== 3'b000 || {nwait0, nwait1, nwait2} !== 3'b111) begin
                bad++;
                $display("FAIL unsel_wr cyc=%0d sel=%b%b%b nwait=%b%b%b want 000/111",
                         c, sel0, sel1, sel2, nwait0, nwait1, nwait2);
            end
        end
        // Same unselected address as a read with the bus left floating.
        RnW   = 1'b1;
        nOE   = 1'b0;
        tb_oe = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if (bus0 !== 16'hFFFF || bus1 !== 16'hFFFF || bus2 !== 16'hFFFF) begin
                bad++;
                $display("FAIL unsel_drive cyc=%0d bus=%h/%h/%h want ffff", c, bus0, bus1, bus2);
            end
        end
        bus_release(0);
        do_access(0, 16'h0012, 1'b1, 16'h0000, 1);
        bus_release(0);
    endtask

    task automatic test_abort_ws3();
        do_access(1, 16'h1034, 1'b0, 16'h1111, 3);
        bus_release(1);
        ALE    = 1'b1;
        nME    = 1'b1;
        RnW    = 1'b0;
        tb_dat = 16'h1034;
        tb_oe  = 1'b1;
        tick();
        ALE    = 1'b0;
        nME    = 1'b0;
        tb_dat = 16'h5555;
        tick();
        tick();
        total++;
        if (nwait1 !== 1'b0) begin
            bad++;
            $display("FAIL abort_prewait got=%b want=0", nwait1);
        end
        nME = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if (nwait1 !== 1'b1) begin
                bad++;
                $display("FAIL abort_nwait cyc=%0d got=%b want=1", c, nwait1);
            end
        end
        tb_oe = 1'b0;
        do_access(1, 16'h1034, 1'b1, 16'h0000, 3);
        bus_release(1);
    endtask

    task automatic test_ws0();
        do_access(2, 16'h2040, 1'b0, 16'hA5A5, 0);
        bus_release(2);
        do_access(2, 16'h2040, 1'b1, 16'h0000, 0);
        bus_release(2);
    endtask

    task automatic test_reset_in_hold();
        do_access(0, 16'h0012, 1'b1, 16'h0000, 1);
        nReset = 1'b0;
        tick();
        total++;
        if (bus0 !== 16'hFFFF || nwait0 !== 1'b1 || sel0 !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold bus=%h nwait=%b sel=%b want ffff/1/0", bus0, nwait0, sel0);
        end
        nReset = 1'b1;
        bus_release(0);
        do_access(0, 16'h0012, 1'b1, 16'h0000, 1);
        bus_release(0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] a;
        logic [15:0] d;
        for (int i = 0; i < 5; i++) begin
            a = {8'h00, 8'($urandom_range(0, 255))};
            d = 16'($urandom_range(0, 16'hFFFE));
            // Write then read the same word with no idle gap between accesses.
            do_access(0, a, 1'b0, d, 1);
            do_access(0, a, 1'b1, 16'h0000, 1);
        end
        bus_release(0);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_left got=%0d want=0", exp_q.size());
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_ws1();
        test_read_ws1();
        test_unselected();
        test_abort_ws3();
        test_ws0();
        test_reset_in_hold();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
